ysyx_25020037_axi_arbiter: RTL

Two-master to one-slave AXI4 arbiter sitting directly upstream of the simple-SoC SRAM slave. It merges the IFU master (read-only) and the LSU master (read and write) onto the single SRAM port. Exactly one transaction is in flight at a time. The grant is held from request acceptance until the final response handshake, and is round-robin when both masters request in the same cycle.

---
 rtl/ysyx_25020037_axi_arbiter_if.sv | 56 +++++
 rtl/ysyx_25020037_axi_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_axi_arbiter_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) shared by both masters and the slave port of the arbiter.
// Widths follow ADDR_W/DATA_W; IDs are 4 bits, strobes one bit per data byte.
interface ysyx_25020037_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [3:0]        rid;

  logic              awvalid;
  logic              awready;
  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [3:0]        bid;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rresp, rdata, rlast, rid, output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rresp, rdata, rlast, rid, input rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready
  );
endinterface

// File: rtl/ysyx_25020037_axi_arbiter.sv
// IFU(read)/LSU(read+write) to single AXI slave arbiter, one transaction in flight, round-robin on ties.
// Requests reach the slave 1 cycle after sampling in IDLE; responses pass combinationally.
module ysyx_25020037_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_25020037_axi_arbiter_if.slave  ifu,
  ysyx_25020037_axi_arbiter_if.slave  lsu,
  ysyx_25020037_axi_arbiter_if.master s
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state, state_n;
  logic        owner, owner_n;
  logic        last_grant, last_grant_n;
  logic [3:0]  saved_id, saved_id_n;
  logic        aw_done, aw_done_n;
  logic        w_done, w_done_n;
  logic        ifu_pend, lsu_pend, grant_lsu;
  logic [ADDR_W-1:0] ar_addr;
  logic [DATA_W-1:0] r_data;

  assign ifu_pend  = ifu.arvalid;
  assign lsu_pend  = lsu.arvalid | (lsu.awvalid & lsu.wvalid);
  assign grant_lsu = lsu_pend & (~ifu_pend | ~last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      saved_id   <= 4'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      saved_id   <= saved_id_n;
      aw_done    <= aw_done_n;
      w_done     <= w_done_n;
    end
  end

  // Payloads are steered by owner only; the valids below decide when they matter.
  assign ar_addr   = owner ? lsu.araddr : ifu.araddr;
  assign s.araddr  = ar_addr;
  assign s.arid    = {3'b000, owner};
  assign s.arlen   = owner ? lsu.arlen   : ifu.arlen;
  assign s.arsize  = owner ? lsu.arsize  : ifu.arsize;
  assign s.arburst = owner ? lsu.arburst : ifu.arburst;

  assign s.awid    = {3'b000, owner};
  assign s.awaddr  = lsu.awaddr;
  assign s.awlen   = lsu.awlen;
  assign s.awsize  = lsu.awsize;
  assign s.awburst = lsu.awburst;
  assign s.wdata   = lsu.wdata;
  assign s.wstrb   = lsu.wstrb;
  assign s.wlast   = lsu.wlast;

  assign r_data    = s.rdata;
  assign ifu.rdata = r_data;
  assign lsu.rdata = r_data;
  assign ifu.rresp = s.rresp;
  assign lsu.rresp = s.rresp;
  assign ifu.rlast = s.rlast;
  assign lsu.rlast = s.rlast;
  assign ifu.rid   = saved_id;
  assign lsu.rid   = saved_id;
  assign lsu.bresp = s.bresp;
  assign lsu.bid   = saved_id;

  // The IFU never writes.
  assign ifu.awready = 1'b0;
  assign ifu.wready  = 1'b0;
  assign ifu.bvalid  = 1'b0;
  assign ifu.bresp   = 2'b00;
  assign ifu.bid     = 4'd0;

  logic unused_sig;
  assign unused_sig = ^{ifu.awvalid, ifu.awid, ifu.awaddr, ifu.awlen, ifu.awsize, ifu.awburst,
                        ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.bready, s.rid, s.bid};

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_grant_n = last_grant;
    saved_id_n   = saved_id;
    aw_done_n    = aw_done;
    w_done_n     = w_done;
    s.arvalid    = 1'b0;
    s.awvalid    = 1'b0;
    s.wvalid     = 1'b0;
    s.rready     = 1'b0;
    s.bready     = 1'b0;
    ifu.arready  = 1'b0;
    ifu.rvalid   = 1'b0;
    lsu.arready  = 1'b0;
    lsu.rvalid   = 1'b0;
    lsu.awready  = 1'b0;
    lsu.wready   = 1'b0;
    lsu.bvalid   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          // Stray responses are swallowed so the slave cannot stall.
          s.rready  = s.rvalid;
          s.bready  = s.bvalid;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          if (ifu_pend | lsu_pend) begin
            owner_n      = grant_lsu;
            last_grant_n = grant_lsu;
            if (!grant_lsu) begin
              state_n    = RD;
              saved_id_n = ifu.arid;
            end else if (lsu.arvalid) begin
              state_n    = RD;
              saved_id_n = lsu.arid;
            end else begin
              state_n    = WR;
              saved_id_n = lsu.awid;
            end
          end
        end
        RD: begin
          s.arvalid   = owner ? lsu.arvalid : ifu.arvalid;
          ifu.arready = ~owner & s.arready;
          lsu.arready =  owner & s.arready;
          ifu.rvalid  = ~owner & s.rvalid;
          lsu.rvalid  =  owner & s.rvalid;
          s.rready    = owner ? lsu.rready : ifu.rready;
          if (s.rvalid && s.rready && s.rlast) state_n = IDLE;
        end
        WR: begin
          s.awvalid   = lsu.awvalid & ~aw_done;
          s.wvalid    = lsu.wvalid & ~w_done;
          lsu.awready = s.awready & ~aw_done;
          lsu.wready  = s.wready & ~w_done;
          lsu.bvalid  = s.bvalid;
          s.bready    = lsu.bready;
          if (s.awvalid && s.awready) aw_done_n = 1'b1;
          if (s.wvalid && s.wready && lsu.wlast) w_done_n = 1'b1;
          if (s.bvalid && s.bready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A response beat with nothing outstanding is a slave protocol error.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    !(state == IDLE && (s.rvalid || s.bvalid)));

endmodule
